wavetable_voice_scheduler: RTL

// Time-multiplexes the single read port of the wavetable BRAM among NUM_VOICES

---
 rtl/wavetable_voice_scheduler.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/wavetable_voice_scheduler.sv
// wavetable_voice_scheduler
// Shares one wavetable BRAM read port among NUM_VOICES voices. On every
// sample tick each voice gets one read slot, its phase accumulator steps,
// and the returned samples are summed into a single mixed sample.
module wavetable_voice_scheduler #(
    parameter int NUM_VOICES   = 4,
    parameter int PHASE_WIDTH  = 32,
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 2,
    parameter int SAMPLE_DIV   = 12500
) (
    input  logic                                          clk_in,
    input  logic                                          rst_n_in,
    input  logic [NUM_VOICES-1:0]                         voice_en_in,
    input  logic [NUM_VOICES*PHASE_WIDTH-1:0]             phase_inc_in,
    output logic [ADDR_WIDTH-1:0]                         addr_out,
    input  logic [DATA_WIDTH-1:0]                         bram_data_in,
    output logic [DATA_WIDTH+$clog2(NUM_VOICES+1)-1:0]    mix_out,
    output logic                                          mix_valid_out,
    output logic                                          busy_out,
    output logic                                          overrun_out
);

    // Wide enough for NUM_VOICES full-scale samples, so the sum never wraps.
    localparam int MIX_WIDTH   = DATA_WIDTH + $clog2(NUM_VOICES + 1);
    localparam int IDX_WIDTH   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int DRAIN_WIDTH = $clog2(READ_LATENCY + 1);
    localparam int TICK_WIDTH  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [IDX_WIDTH-1:0]   LAST_VOICE = IDX_WIDTH'(NUM_VOICES - 1);
    localparam logic [DRAIN_WIDTH-1:0] DRAIN_LAST = DRAIN_WIDTH'(READ_LATENCY - 1);
    localparam logic [TICK_WIDTH-1:0]  TICK_LAST  = TICK_WIDTH'(SAMPLE_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]                   state_reg, state_next;
    logic [IDX_WIDTH-1:0]         voice_idx_reg, voice_idx_next;
    logic [DRAIN_WIDTH-1:0]       drain_cnt_reg, drain_cnt_next;
    logic [TICK_WIDTH-1:0]        tick_cnt_reg;
    logic                         tick;
    logic [READ_LATENCY-1:0]      pipe_valid_reg;
    logic [READ_LATENCY-1:0]      pipe_en_reg;
    logic [MIX_WIDTH-1:0]         acc_reg;
    logic [NUM_VOICES*ADDR_WIDTH-1:0] voice_addr;
    logic [ADDR_WIDTH-1:0]        issue_addr;
    int                           addr_sel;
    logic                         addr_load;
    logic                         issue_active;
    logic                         push_en;

    assign tick         = (tick_cnt_reg == TICK_LAST);
    assign issue_active = (state_reg == ST_ISSUE);
    assign push_en      = voice_en_in[voice_idx_reg];
    assign busy_out     = (state_reg != ST_IDLE);
    // The address register is loaded one cycle ahead so that voice v's
    // address is on the bus during voice v's own issue cycle.
    assign addr_load    = ((state_reg == ST_IDLE) && tick) ||
                          (issue_active && (voice_idx_reg != LAST_VOICE));

    // Sample-rate divider: free-running 0..SAMPLE_DIV-1, tick on the wrap cycle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tick_cnt_reg <= '0;
        end else if (tick) begin
            tick_cnt_reg <= '0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
        end
    end

    // Per-voice phase accumulators; each one steps only in its own issue slot.
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
        logic [PHASE_WIDTH-1:0] phase_reg;
        logic [PHASE_WIDTH-1:0] phase_inc;

        assign phase_inc = phase_inc_in[gi*PHASE_WIDTH +: PHASE_WIDTH];
        assign voice_addr[gi*ADDR_WIDTH +: ADDR_WIDTH] =
            phase_reg[PHASE_WIDTH-1 -: ADDR_WIDTH];

        // A gated-off voice is parked at phase 0 so it restarts cleanly.
        always_ff @(posedge clk_in or negedge rst_n_in) begin
            if (!rst_n_in) begin
                phase_reg <= '0;
            end else if (issue_active && (voice_idx_reg == IDX_WIDTH'(gi))) begin
                phase_reg <= voice_en_in[gi] ? (phase_reg + phase_inc) : '0;
            end
        end
    end

    // Select which voice's address goes out next: voice 0 on the tick, else the following voice.
    always_comb begin
        addr_sel   = issue_active ? (int'(voice_idx_reg) + 1) : 0;
        issue_addr = voice_addr[ADDR_WIDTH-1:0];
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (addr_sel == v) begin
                issue_addr = voice_addr[v*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Sequencer next-state: IDLE -> ISSUE (one slot per voice) -> DRAIN -> DONE.
    always_comb begin
        state_next     = state_reg;
        voice_idx_next = voice_idx_reg;
        drain_cnt_next = drain_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (tick) begin
                    state_next     = ST_ISSUE;
                    voice_idx_next = '0;
                end
            end
            ST_ISSUE: begin
                if (voice_idx_reg == LAST_VOICE) begin
                    state_next     = ST_DRAIN;
                    drain_cnt_next = '0;
                end else begin
                    voice_idx_next = voice_idx_reg + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_reg == DRAIN_LAST) begin
                    state_next = ST_DONE;
                end else begin
                    drain_cnt_next = drain_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg     <= ST_IDLE;
            voice_idx_reg <= '0;
            drain_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            voice_idx_reg <= voice_idx_next;
            drain_cnt_reg <= drain_cnt_next;
        end
    end

    // Read-latency tracker: each issued slot travels READ_LATENCY stages with its gate bit.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pipe_valid_reg <= '0;
            pipe_en_reg    <= '0;
        end else begin
            pipe_valid_reg[0] <= issue_active;
            pipe_en_reg[0]    <= issue_active && push_en;
            for (int k = 1; k < READ_LATENCY; k++) begin
                pipe_valid_reg[k] <= pipe_valid_reg[k-1];
                pipe_en_reg[k]    <= pipe_en_reg[k-1];
            end
        end
    end

    // Mix accumulator: cleared on the tick, adds returned samples of gated-on voices.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc_reg <= '0;
        end else if ((state_reg == ST_IDLE) && tick) begin
            acc_reg <= '0;
        end else if (pipe_valid_reg[READ_LATENCY-1] && pipe_en_reg[READ_LATENCY-1]) begin
            acc_reg <= acc_reg + MIX_WIDTH'(bram_data_in);
        end
    end

    // Registered outputs: BRAM address, published mix with its strobe, sticky overrun flag.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_out      <= '0;
            mix_out       <= '0;
            mix_valid_out <= 1'b0;
            overrun_out   <= 1'b0;
        end else begin
            if (addr_load) begin
                addr_out <= issue_addr;
            end
            mix_valid_out <= (state_reg == ST_DONE);
            if (state_reg == ST_DONE) begin
                mix_out <= acc_reg;
            end
            if (tick && (state_reg != ST_IDLE)) begin
                overrun_out <= 1'b1;
            end
        end
    end

endmodule
